// File: rtl/frame_latch.sv
// ============================================================================
// Module   : frame_latch
// Purpose  : Multi-channel, frame-synchronous latch between the UART receive
//            path and the renderer. Words are staged per channel and all
//            staged channels are published together on the falling edge of
//            n_vsync, so render-side values only change at frame boundaries.
//            Also reports which channels changed, counts overruns (saturating)
//            and commits (wrapping), and optionally holds publication until
//            every channel has fresh data (ATOMIC).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_latch #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int ATOMIC   = 0,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         i_clk,
  input  logic                         n_rst,
  input  logic                         n_vsync,
  input  logic                         valid_data,
  input  logic [CH_W-1:0]              chan,
  input  logic [WIDTH-1:0]             uart_buf,
  output logic [CHANNELS*WIDTH-1:0]    render_pos,
  output logic [CHANNELS-1:0]          updated,
  output logic                         commit,
  output logic [CNT_W-1:0]             overrun_cnt,
  output logic [CNT_W-1:0]             frame_cnt
);

  localparam bit ATOMIC_MODE = (ATOMIC != 0);

  // Registered state and next-state values
  logic                              vs_q,      vs_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    stage_q,   stage_d;
  logic [CHANNELS-1:0]               pending_q, pending_d;
  logic [CHANNELS*WIDTH-1:0]         render_q,  render_d;
  logic [CHANNELS-1:0]               updated_q, updated_d;
  logic                              commit_q,  commit_d;
  logic [CNT_W-1:0]                  overrun_q, overrun_d;
  logic [CNT_W-1:0]                  frame_q,   frame_d;

  // Per-cycle control terms
  logic [CHANNELS-1:0]               cap_sel;
  logic                              fe;
  logic                              do_commit;
  logic                              ovr_hit;

  // Decode the capture strobe into a one-hot channel select. Indices at or
  // beyond CHANNELS match no bit, so invalid channels are silently dropped.
  always_comb begin
    cap_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cap_sel[k] = valid_data && (chan == CH_W'(k));
    end
  end

  // Frame edge, commit decision and overrun detection. A capture that
  // collides with a commit is not an overrun: the old word is being
  // published in this very cycle, so nothing is lost.
  always_comb begin
    fe        = vs_q & ~n_vsync;
    do_commit = fe & (~ATOMIC_MODE | (&pending_q));
    ovr_hit   = (|(cap_sel & pending_q)) & ~do_commit;
  end

  // Staging registers and pending flags. Commit clears all flags first so a
  // same-cycle capture re-arms its channel for the following frame.
  always_comb begin
    stage_d   = stage_q;
    pending_d = do_commit ? '0 : pending_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cap_sel[k]) begin
        stage_d[k]   = uart_buf;
        pending_d[k] = 1'b1;
      end
    end
  end

  // Publication: copy the pre-cycle staged word of every pending channel.
  // An fe that does not commit clears the change mask.
  always_comb begin
    render_d  = render_q;
    updated_d = updated_q;
    commit_d  = do_commit;
    if (do_commit) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (pending_q[k]) begin
          render_d[k*WIDTH +: WIDTH] = stage_q[k];
        end
      end
    end
    if (fe) begin
      updated_d = do_commit ? pending_q : '0;
    end
  end

  // Statistics: saturating overrun count and wrapping frame count.
  always_comb begin
    overrun_d = overrun_q;
    frame_d   = frame_q;
    if (ovr_hit && (overrun_q != {CNT_W{1'b1}})) begin
      overrun_d = overrun_q + CNT_W'(1);
    end
    if (do_commit) begin
      frame_d = frame_q + CNT_W'(1);
    end
  end

  // Sync history; vs_q resets high so a low n_vsync at reset release fires fe.
  always_comb begin
    vs_d = n_vsync;
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge n_rst) begin
    if (!n_rst) begin
      vs_q      <= 1'b1;
      stage_q   <= '0;
      pending_q <= '0;
      render_q  <= '0;
      updated_q <= '0;
      commit_q  <= 1'b0;
      overrun_q <= '0;
      frame_q   <= '0;
    end else begin
      vs_q      <= vs_d;
      stage_q   <= stage_d;
      pending_q <= pending_d;
      render_q  <= render_d;
      updated_q <= updated_d;
      commit_q  <= commit_d;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
    end
  end

  assign render_pos  = render_q;
  assign updated     = updated_q;
  assign commit      = commit_q;
  assign overrun_cnt = overrun_q;
  assign frame_cnt   = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_latch.sv
// ============================================================================
// Module   : tb_frame_latch
// Purpose  : Self-checking bench for frame_latch. Two instances:
//            u_dut0 : CHANNELS=3, CNT_W=2, ATOMIC=0
//            u_dut1 : CHANNELS=2, CNT_W=8, ATOMIC=1
//            Per-cycle vectors with expected outputs are queued as they are
//            driven and compared after the sampling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_latch;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 signals
  logic        n_rst0, vsync0, valid0;
  logic [1:0]  chan0;
  logic [31:0] data0;
  logic [95:0] render0;
  logic [2:0]  upd0;
  logic        commit0;
  logic [1:0]  ovr0, fr0;

  // Instance 1 signals
  logic        n_rst1, vsync1, valid1;
  logic [0:0]  chan1;
  logic [31:0] data1;
  logic [63:0] render1;
  logic [1:0]  upd1;
  logic        commit1;
  logic [7:0]  ovr1, fr1;

  frame_latch #(.WIDTH(32), .CHANNELS(3), .CNT_W(2), .ATOMIC(0)) u_dut0 (
    .i_clk(clk), .n_rst(n_rst0), .n_vsync(vsync0), .valid_data(valid0),
    .chan(chan0), .uart_buf(data0), .render_pos(render0), .updated(upd0),
    .commit(commit0), .overrun_cnt(ovr0), .frame_cnt(fr0)
  );

  frame_latch #(.WIDTH(32), .CHANNELS(2), .CNT_W(8), .ATOMIC(1)) u_dut1 (
    .i_clk(clk), .n_rst(n_rst1), .n_vsync(vsync1), .valid_data(valid1),
    .chan(chan1), .uart_buf(data1), .render_pos(render1), .updated(upd1),
    .commit(commit1), .overrun_cnt(ovr1), .frame_cnt(fr1)
  );

  typedef struct {
    bit          dut;
    logic        v;
    logic [1:0]  ch;
    logic [31:0] d;
    logic        vs;
    logic [95:0] r;
    logic [2:0]  u;
    logic        cm;
    logic [7:0]  ov;
    logic [7:0]  fr;
  } vec_t;

  typedef struct {
    bit          dut;
    string       name;
    logic [95:0] r;
    logic [2:0]  u;
    logic        cm;
    logic [7:0]  ov;
    logic [7:0]  fr;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(bit dut, logic v, logic [1:0] ch, logic [31:0] d,
                              logic vs, logic [31:0] r0, logic [31:0] r1,
                              logic [31:0] r2, logic [2:0] u, logic cm,
                              logic [7:0] ov, logic [7:0] fr);
    vec_t t;
    t.dut = dut; t.v = v; t.ch = ch; t.d = d; t.vs = vs;
    t.r = {r2, r1, r0}; t.u = u; t.cm = cm; t.ov = ov; t.fr = fr;
    return t;
  endfunction

  // Compare one expected record against the current outputs of its instance.
  task automatic compare(input exp_t e);
    logic [95:0] ar;
    logic [2:0]  au;
    logic        acm;
    logic [7:0]  aov, afr;
    if (e.dut == 1'b0) begin
      ar = render0; au = upd0; acm = commit0;
      aov = {6'b0, ovr0}; afr = {6'b0, fr0};
    end else begin
      ar = {32'b0, render1}; au = {1'b0, upd1}; acm = commit1;
      aov = ovr1; afr = fr1;
    end
    total++;
    if (ar !== e.r || au !== e.u || acm !== e.cm || aov !== e.ov || afr !== e.fr) begin
      bad++;
      $display("FAIL %s: got render=%h upd=%b commit=%b ovr=%0d frame=%0d, want render=%h upd=%b commit=%b ovr=%0d frame=%0d",
               e.name, ar, au, acm, aov, afr, e.r, e.u, e.cm, e.ov, e.fr);
    end
  endtask

  // Drive one vector, queue its expectation, then check after the edge.
  task automatic apply(input vec_t t, input string name);
    exp_t e;
    exp_t got;
    @(negedge clk);
    if (t.dut == 1'b0) begin
      valid0 = t.v; chan0 = t.ch; data0 = t.d; vsync0 = t.vs;
      valid1 = 1'b0; vsync1 = 1'b1;
    end else begin
      valid1 = t.v; chan1 = t.ch[0]; data1 = t.d; vsync1 = t.vs;
      valid0 = 1'b0; vsync0 = 1'b1;
    end
    e.dut = t.dut; e.name = name; e.r = t.r; e.u = t.u;
    e.cm = t.cm; e.ov = t.ov; e.fr = t.fr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty, got nothing want one entry", name);
    end else begin
      got = sb.pop_front();
      compare(got);
    end
  endtask

  task automatic check_zero(input bit dut, input string name);
    exp_t e;
    e.dut = dut; e.name = name; e.r = '0; e.u = '0; e.cm = 1'b0; e.ov = '0; e.fr = '0;
    compare(e);
  endtask

  initial begin
    n_rst0 = 1'b0; n_rst1 = 1'b0;
    vsync0 = 1'b1; vsync1 = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0;
    chan0 = '0; chan1 = '0; data0 = '0; data1 = '0;

    // Instance 0: basic publish
    tbl.push_back(mk(0,0,0,32'h0,1,         0,0,0,             3'b000,0,0,0));
    tbl.push_back(mk(0,1,0,32'h1234,1,      0,0,0,             3'b000,0,0,0));
    tbl.push_back(mk(0,1,1,32'h5678,1,      0,0,0,             3'b000,0,0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,         32'h1234,32'h5678,0,3'b011,1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,0,         32'h1234,32'h5678,0,3'b011,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,0,         32'h1234,32'h5678,0,3'b011,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,1,         32'h1234,32'h5678,0,3'b011,0,0,1));
    // partial update, invalid channel 3
    tbl.push_back(mk(0,1,1,32'hAA,1,        32'h1234,32'h5678,0,3'b011,0,0,1));
    tbl.push_back(mk(0,1,3,32'hDEAD,1,      32'h1234,32'h5678,0,3'b011,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,0,         32'h1234,32'hAA,0,  3'b010,1,0,2));
    tbl.push_back(mk(0,0,0,32'h0,1,         32'h1234,32'hAA,0,  3'b010,0,0,2));
    // collision: 0x22 captured on the fe cycle
    tbl.push_back(mk(0,1,0,32'h11,1,        32'h1234,32'hAA,0,  3'b010,0,0,2));
    tbl.push_back(mk(0,1,0,32'h22,0,        32'h11,32'hAA,0,    3'b001,1,0,3));
    tbl.push_back(mk(0,0,0,32'h0,0,         32'h11,32'hAA,0,    3'b001,0,0,3));
    tbl.push_back(mk(0,0,0,32'h0,1,         32'h11,32'hAA,0,    3'b001,0,0,3));
    tbl.push_back(mk(0,0,0,32'h0,0,         32'h22,32'hAA,0,    3'b001,1,0,0));
    tbl.push_back(mk(0,0,0,32'h0,1,         32'h22,32'hAA,0,    3'b001,0,0,0));
    // empty commit
    tbl.push_back(mk(0,0,0,32'h0,0,         32'h22,32'hAA,0,    3'b000,1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,1,         32'h22,32'hAA,0,    3'b000,0,0,1));
    // overrun, then saturation of the 2-bit counter
    tbl.push_back(mk(0,1,0,32'h1,1,         32'h22,32'hAA,0,    3'b000,0,0,1));
    tbl.push_back(mk(0,1,0,32'h2,1,         32'h22,32'hAA,0,    3'b000,0,1,1));
    tbl.push_back(mk(0,1,0,32'h3,1,         32'h22,32'hAA,0,    3'b000,0,2,1));
    tbl.push_back(mk(0,0,0,32'h0,0,         32'h3,32'hAA,0,     3'b001,1,2,2));
    tbl.push_back(mk(0,0,0,32'h0,1,         32'h3,32'hAA,0,     3'b001,0,2,2));
    tbl.push_back(mk(0,1,2,32'h10,1,        32'h3,32'hAA,0,     3'b001,0,2,2));
    tbl.push_back(mk(0,1,2,32'h11,1,        32'h3,32'hAA,0,     3'b001,0,3,2));
    tbl.push_back(mk(0,1,2,32'h12,1,        32'h3,32'hAA,0,     3'b001,0,3,2));
    tbl.push_back(mk(0,1,2,32'h13,1,        32'h3,32'hAA,0,     3'b001,0,3,2));
    tbl.push_back(mk(0,0,0,32'h0,0,         32'h3,32'hAA,32'h13,3'b100,1,3,3));
    tbl.push_back(mk(0,0,0,32'h0,1,         32'h3,32'hAA,32'h13,3'b100,0,3,3));
    // Instance 1 (ATOMIC): partial frame holds, full frame publishes
    tbl.push_back(mk(1,1,0,32'h100,1,       0,0,0,              3'b000,0,0,0));
    tbl.push_back(mk(1,0,0,32'h0,0,         0,0,0,              3'b000,0,0,0));
    tbl.push_back(mk(1,0,0,32'h0,1,         0,0,0,              3'b000,0,0,0));
    tbl.push_back(mk(1,1,1,32'h200,1,       0,0,0,              3'b000,0,0,0));
    tbl.push_back(mk(1,0,0,32'h0,0,         32'h100,32'h200,0,  3'b011,1,0,1));
    tbl.push_back(mk(1,0,0,32'h0,1,         32'h100,32'h200,0,  3'b011,0,0,1));
    tbl.push_back(mk(1,1,0,32'h300,1,       32'h100,32'h200,0,  3'b011,0,0,1));
    tbl.push_back(mk(1,0,0,32'h0,0,         32'h100,32'h200,0,  3'b000,0,0,1));
    tbl.push_back(mk(1,0,0,32'h0,1,         32'h100,32'h200,0,  3'b000,0,0,1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    @(negedge clk);
    n_rst0 = 1'b1; n_rst1 = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset mid-operation on instance 0 with data pending
    apply(mk(0,1,1,32'h99,1, 32'h3,32'hAA,32'h13,3'b100,0,3,3), "pre_rst");
    @(negedge clk);
    valid0 = 1'b0;
    #1 n_rst0 = 1'b0;
    #1 check_zero(0, "async_rst");
    @(negedge clk);
    n_rst0 = 1'b1;
    apply(mk(0,0,0,32'h0,0, 0,0,0,3'b000,1,0,1), "post_rst_commit");
    apply(mk(0,0,0,32'h0,1, 0,0,0,3'b000,0,0,1), "post_rst_idle");

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_drain: got %0d leftover entries want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
